// File: rtl/axis_to_axi4_writer_pkg.sv
// Shared AXI4 constants, AW FSM state type and a size helper for the stream-to-AXI4 writer.
package axi4_defs;

    localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
    localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

    typedef enum logic [1:0] {
        AW_IDLE,
        AW_ISSUE,
        AW_WAIT
    } aw_state_t;

    // AxSIZE encoding for a beat of n bytes (n a power of two, 1..128)
    function automatic logic [2:0] log2_bytes(input int unsigned n);
        logic [2:0] r;
        r = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if ((32'd1 << i) == n) r = 3'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/burst_len_fifo.sv
// First-word-fall-through FIFO carrying accepted AWLEN values to the W path.
module burst_len_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));

    // storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // pointer and occupancy tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axis_to_axi4_writer.sv
// Write-only AXI4 master draining an AXI-Stream into memory as INCR bursts.
module axis_to_axi4_writer
    import axi4_defs::*;
#(
    parameter int DW              = 512,
    parameter int AW              = 64,
    parameter int IW              = 5,
    parameter int BURST_BEATS     = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [AW-1:0]   dst_addr,
    input  logic [31:0]     beat_count,
    output logic            busy,
    output logic            done,
    output logic            error,
    input  logic [DW-1:0]   axis_tdata,
    input  logic            axis_tvalid,
    output logic            axis_tready,
    output logic [AW-1:0]   M_AXI_AWADDR,
    output logic [7:0]      M_AXI_AWLEN,
    output logic [2:0]      M_AXI_AWSIZE,
    output logic [IW-1:0]   M_AXI_AWID,
    output logic [1:0]      M_AXI_AWBURST,
    output logic            M_AXI_AWLOCK,
    output logic [3:0]      M_AXI_AWCACHE,
    output logic [3:0]      M_AXI_AWQOS,
    output logic [2:0]      M_AXI_AWPROT,
    output logic            M_AXI_AWVALID,
    input  logic            M_AXI_AWREADY,
    output logic [DW-1:0]   M_AXI_WDATA,
    output logic [DW/8-1:0] M_AXI_WSTRB,
    output logic            M_AXI_WLAST,
    output logic            M_AXI_WVALID,
    input  logic            M_AXI_WREADY,
    input  logic [1:0]      M_AXI_BRESP,
    input  logic            M_AXI_BVALID,
    output logic            M_AXI_BREADY
);

    localparam int          BYTES     = DW / 8;
    localparam int          OW        = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0] BURST_MAX = 32'(BURST_BEATS);

    aw_state_t     aw_state, aw_next;
    logic [AW-1:0] aw_addr;
    logic [31:0]   aw_remain;
    logic [31:0]   b_remain;
    logic [OW-1:0] outstanding;
    logic [31:0]   aw_beats;
    logic [31:0]   b_beats;
    logic          start_ok;
    logic          issue_ok;
    logic          aw_hs;
    logic          b_hs;
    logic          b_last;

    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic          fifo_empty;
    logic          fifo_full;
    logic          w_active;
    logic [7:0]    w_len;
    logic [7:0]    w_idx;
    logic          w_hs;

    assign start_ok = start & ~busy;
    assign aw_beats = (aw_remain > BURST_MAX) ? BURST_MAX : aw_remain;
    // bursts are all full-size except the tail, so the B being retired is min(b_remain, max)
    assign b_beats  = (b_remain > BURST_MAX) ? BURST_MAX : b_remain;
    assign issue_ok = (aw_remain != '0) & (outstanding < OW'(MAX_OUTSTANDING)) & ~fifo_full;
    assign aw_hs    = M_AXI_AWVALID & M_AXI_AWREADY;
    assign b_hs     = M_AXI_BVALID & M_AXI_BREADY;
    assign b_last   = b_hs & (b_remain <= BURST_MAX);

    assign M_AXI_AWADDR  = aw_addr;
    assign M_AXI_AWLEN   = 8'(aw_beats - 32'd1);
    assign M_AXI_AWSIZE  = log2_bytes(BYTES);
    assign M_AXI_AWID    = '0;
    assign M_AXI_AWBURST = AXI_BURST_INCR;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = AXI_CACHE_DEFAULT;
    assign M_AXI_AWQOS   = '0;
    assign M_AXI_AWPROT  = '0;
    assign M_AXI_BREADY  = busy;

    assign fifo_pop     = ~w_active & ~fifo_empty;
    assign M_AXI_WVALID = axis_tvalid & w_active;
    assign axis_tready  = M_AXI_WREADY & w_active;
    assign M_AXI_WDATA  = axis_tdata;
    assign M_AXI_WSTRB  = '1;
    assign M_AXI_WLAST  = w_active & (w_idx == w_len);
    assign w_hs         = M_AXI_WVALID & M_AXI_WREADY;

    burst_len_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (8)
    ) u_len_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (aw_hs),
        .din   (M_AXI_AWLEN),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // AW FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) aw_state <= AW_IDLE;
        else       aw_state <= aw_next;
    end

    // AW FSM next state and AWVALID; fields only move on handshake so they hold while valid
    always_comb begin
        aw_next       = aw_state;
        M_AXI_AWVALID = 1'b0;
        case (aw_state)
            AW_IDLE: begin
                if (start_ok && beat_count != '0) aw_next = AW_WAIT;
            end
            AW_WAIT: begin
                if (aw_remain == '0) aw_next = AW_IDLE;
                else if (issue_ok)   aw_next = AW_ISSUE;
            end
            AW_ISSUE: begin
                M_AXI_AWVALID = 1'b1;
                if (M_AXI_AWREADY) aw_next = (aw_remain == aw_beats) ? AW_IDLE : AW_WAIT;
            end
            default: aw_next = AW_IDLE;
        endcase
    end

    // address, remaining-beat and outstanding-burst bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_addr     <= '0;
            aw_remain   <= '0;
            b_remain    <= '0;
            outstanding <= '0;
        end else begin
            if (start_ok) begin
                aw_addr   <= dst_addr;
                aw_remain <= beat_count;
                b_remain  <= beat_count;
            end else begin
                if (aw_hs) begin
                    aw_addr   <= aw_addr + AW'(aw_beats * 32'(BYTES));
                    aw_remain <= aw_remain - aw_beats;
                end
                if (b_hs) b_remain <= b_remain - b_beats;
            end
            case ({aw_hs, b_hs})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // busy/done/error; start is only taken while idle and B only while busy, so they never collide
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start_ok) begin
                error <= 1'b0;
                if (beat_count == '0) done <= 1'b1;
                else                  busy <= 1'b1;
            end
            if (b_hs) begin
                if (M_AXI_BRESP != AXI_RESP_OKAY) error <= 1'b1;
                if (b_last) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            end
        end
    end

    // W burst tracking: load a length from the FIFO, count beats, end on WLAST handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_active <= 1'b0;
            w_len    <= '0;
            w_idx    <= '0;
        end else if (w_hs) begin
            if (M_AXI_WLAST) w_active <= 1'b0;
            else             w_idx    <= w_idx + 1'b1;
        end else if (fifo_pop) begin
            w_active <= 1'b1;
            w_len    <= fifo_dout;
            w_idx    <= '0;
        end
    end

endmodule

// File: tb/tb_axis_to_axi4_writer.sv
// Randomized self-checking bench for axis_to_axi4_writer with a queue-based reference model.
module tb_axis_to_axi4_writer;

    localparam int DW    = 512;
    localparam int AW    = 64;
    localparam int IW    = 5;
    localparam int BB    = 64;
    localparam int MO    = 4;
    localparam int BYTES = DW / 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [AW-1:0]   dst_addr = '0;
    logic [31:0]     beat_count = '0;
    logic            busy, done, error;
    logic [DW-1:0]   axis_tdata = '0;
    logic            axis_tvalid = 1'b0;
    logic            axis_tready;
    logic [AW-1:0]   M_AXI_AWADDR;
    logic [7:0]      M_AXI_AWLEN;
    logic [2:0]      M_AXI_AWSIZE;
    logic [IW-1:0]   M_AXI_AWID;
    logic [1:0]      M_AXI_AWBURST;
    logic            M_AXI_AWLOCK;
    logic [3:0]      M_AXI_AWCACHE;
    logic [3:0]      M_AXI_AWQOS;
    logic [2:0]      M_AXI_AWPROT;
    logic            M_AXI_AWVALID;
    logic            M_AXI_AWREADY = 1'b0;
    logic [DW-1:0]   M_AXI_WDATA;
    logic [DW/8-1:0] M_AXI_WSTRB;
    logic            M_AXI_WLAST;
    logic            M_AXI_WVALID;
    logic            M_AXI_WREADY = 1'b0;
    logic [1:0]      M_AXI_BRESP = 2'b00;
    logic            M_AXI_BVALID = 1'b0;
    logic            M_AXI_BREADY;

    axis_to_axi4_writer #(
        .DW              (DW),
        .AW              (AW),
        .IW              (IW),
        .BURST_BEATS     (BB),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .dst_addr      (dst_addr),
        .beat_count    (beat_count),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .axis_tdata    (axis_tdata),
        .axis_tvalid   (axis_tvalid),
        .axis_tready   (axis_tready),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWLEN   (M_AXI_AWLEN),
        .M_AXI_AWSIZE  (M_AXI_AWSIZE),
        .M_AXI_AWID    (M_AXI_AWID),
        .M_AXI_AWBURST (M_AXI_AWBURST),
        .M_AXI_AWLOCK  (M_AXI_AWLOCK),
        .M_AXI_AWCACHE (M_AXI_AWCACHE),
        .M_AXI_AWQOS   (M_AXI_AWQOS),
        .M_AXI_AWPROT  (M_AXI_AWPROT),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WLAST   (M_AXI_WLAST),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_w_q[$];
    bit            exp_wlast_q[$];
    logic [AW-1:0] exp_aw_addr_q[$];
    logic [7:0]    exp_aw_len_q[$];
    logic [AW-1:0] obs_aw_addr[$];
    logic [7:0]    obs_aw_len[$];
    int n_bursts, exp_total, err_idx;
    int aw_seen, w_bursts, w_beats, b_done, b_sent, done_cnt;
    int cyc, b_hs_cyc, start_cyc;
    int p_tv, p_wr, p_awr;
    bit b_hold, start_req;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_cnt;
    bit hs_aw, hs_w, hs_ax, hs_b;
    bit aw_stall_prev;
    logic [AW-1:0] prev_awaddr;
    logic [7:0]    prev_awlen;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // per-cycle compare against the model, sampled at the falling edge
    task automatic observe();
        hs_aw = M_AXI_AWVALID & M_AXI_AWREADY;
        hs_w  = M_AXI_WVALID & M_AXI_WREADY;
        hs_ax = axis_tvalid & axis_tready;
        hs_b  = M_AXI_BVALID & M_AXI_BREADY;
        if (M_AXI_AWVALID)
            check("aw_const", {M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWCACHE, M_AXI_AWID,
                               M_AXI_AWLOCK, M_AXI_AWQOS, M_AXI_AWPROT},
                  {3'd6, 2'b01, 4'b0011, 5'd0, 1'b0, 4'd0, 3'd0});
        if (aw_stall_prev)
            check("aw_hold", {M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_AWLEN}, {1'b1, prev_awaddr, prev_awlen});
        aw_stall_prev = M_AXI_AWVALID & ~M_AXI_AWREADY;
        prev_awaddr   = M_AXI_AWADDR;
        prev_awlen    = M_AXI_AWLEN;
        if (M_AXI_WVALID) begin
            check("wvalid_needs_tvalid", axis_tvalid, 1);
            check("wdata_passthru", M_AXI_WDATA, axis_tdata);
            check("wstrb", M_AXI_WSTRB, {(DW/8){1'b1}});
        end
        if (axis_tvalid) check("tready", axis_tready, M_AXI_WREADY & M_AXI_WVALID);
        check("bready_busy", M_AXI_BREADY, busy);
        if (start && !busy) start_cyc = cyc;
        if (hs_aw) begin
            if (exp_aw_addr_q.size() == 0) check("aw_count", aw_seen + 1, n_bursts);
            else begin
                check("awaddr", M_AXI_AWADDR, exp_aw_addr_q.pop_front());
                check("awlen", M_AXI_AWLEN, exp_aw_len_q.pop_front());
            end
            obs_aw_addr.push_back(M_AXI_AWADDR);
            obs_aw_len.push_back(M_AXI_AWLEN);
            aw_seen++;
        end
        if (hs_w) begin
            if (exp_w_q.size() == 0) check("w_count", w_beats + 1, exp_total);
            else begin
                check("wdata", M_AXI_WDATA, exp_w_q.pop_front());
                check("wlast", M_AXI_WLAST, exp_wlast_q.pop_front());
            end
            w_beats++;
            if (M_AXI_WLAST) w_bursts++;
        end
        if (hs_b) begin
            b_done++;
            b_hs_cyc = cyc;
        end
        check("outstanding_le_max", (aw_seen - b_done) > MO, 0);
        if (done) begin
            done_cnt++;
            check("done_busy_low", busy, 0);
            if (n_bursts > 0) check("done_after_b", cyc - b_hs_cyc, 1);
            else              check("done_after_start", cyc - start_cyc, 1);
        end
    endtask

    // drive after the rising edge, then observe at the falling edge
    task automatic step();
        @(posedge clk);
        #1;
        if (hs_ax && src_q.size() > 0) void'(src_q.pop_front());
        if (hs_b) M_AXI_BVALID = 1'b0;
        start = start_req;
        if (start_req) begin
            dst_addr   = req_addr;
            beat_count = req_cnt;
        end
        start_req = 1'b0;
        if (!(axis_tvalid && !hs_ax)) begin
            if (src_q.size() > 0 && $urandom_range(99) < p_tv) begin
                axis_tvalid = 1'b1;
                axis_tdata  = src_q[0];
            end else axis_tvalid = 1'b0;
        end
        M_AXI_WREADY  = ($urandom_range(99) < p_wr);
        M_AXI_AWREADY = ($urandom_range(99) < p_awr);
        if (!M_AXI_BVALID && !b_hold && b_sent < aw_seen && b_sent < w_bursts) begin
            M_AXI_BVALID = 1'b1;
            M_AXI_BRESP  = (b_sent == err_idx) ? 2'b10 : 2'b00;
            b_sent++;
        end
        @(negedge clk);
        cyc++;
        observe();
    endtask

    task automatic start_transfer(input logic [AW-1:0] addr, input int cnt, input int eidx);
        int rem;
        src_q.delete(); exp_w_q.delete(); exp_wlast_q.delete();
        exp_aw_addr_q.delete(); exp_aw_len_q.delete();
        obs_aw_addr.delete(); obs_aw_len.delete();
        for (int i = 0; i < cnt; i++) begin
            logic [DW-1:0] d;
            d = rand_beat();
            src_q.push_back(d);
            exp_w_q.push_back(d);
            exp_wlast_q.push_back((i % BB == BB - 1) || (i == cnt - 1));
        end
        n_bursts = (cnt + BB - 1) / BB;
        for (int k = 0; k < n_bursts; k++) begin
            rem = cnt - k * BB;
            exp_aw_addr_q.push_back(addr + AW'(k * BB * BYTES));
            exp_aw_len_q.push_back(8'((rem > BB ? BB : rem) - 1));
        end
        exp_total = cnt; err_idx = eidx;
        aw_seen = 0; w_bursts = 0; w_beats = 0; b_done = 0; b_sent = 0; done_cnt = 0;
        req_addr = addr; req_cnt = 32'(cnt); start_req = 1'b1;
        step();
        step();
        check("err_clear_on_start", error, 0);
        check("busy_after_start", busy, cnt > 0);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        check("done_seen", done_cnt, 1);
        check("aw_remaining", exp_aw_addr_q.size(), 0);
        check("w_remaining", exp_w_q.size(), 0);
        check("error_at_done", error, (err_idx >= 0) && (err_idx < n_bursts));
        repeat (3) step();
        check("done_once", done_cnt, 1);
        check("idle_busy", busy, 0);
    endtask

    task automatic clear_model();
        src_q.delete(); exp_w_q.delete(); exp_wlast_q.delete();
        exp_aw_addr_q.delete(); exp_aw_len_q.delete();
        axis_tvalid = 1'b0; M_AXI_BVALID = 1'b0; start = 1'b0;
        hs_aw = 0; hs_w = 0; hs_ax = 0; hs_b = 0; aw_stall_prev = 0;
        n_bursts = 0; exp_total = 0; err_idx = -1;
        aw_seen = 0; w_bursts = 0; w_beats = 0; b_done = 0; b_sent = 0; done_cnt = 0;
    endtask

    initial begin
        cyc = 0; b_hs_cyc = 0; start_cyc = 0; start_req = 0; b_hold = 0;
        p_tv = 100; p_wr = 100; p_awr = 100;
        clear_model();
        #3 reset = 1'b1;
        #2;
        check("reset_outputs", {busy, done, error, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_WLAST, axis_tready}, 0);
        repeat (3) step();
        reset = 1'b0;
        repeat (2) step();

        // single full burst
        start_transfer(64'h1000, 64, -1);
        wait_done(2000);
        check("single_aw_n", obs_aw_addr.size(), 1);
        check("single_addr", obs_aw_addr[0], 64'h1000);
        check("single_len", obs_aw_len[0], 63);
        check("single_beats", w_beats, 64);

        // partial tail burst
        start_transfer(64'h1000, 150, -1);
        wait_done(2000);
        check("tail_aw_n", obs_aw_addr.size(), 3);
        check("tail_addr", {obs_aw_addr[0], obs_aw_addr[1], obs_aw_addr[2]},
              {64'h1000, 64'h2000, 64'h3000});
        check("tail_len", {obs_aw_len[0], obs_aw_len[1], obs_aw_len[2]}, {8'd63, 8'd63, 8'd21});
        check("tail_beats", w_beats, 150);

        // B withheld: AW must stop at MAX_OUTSTANDING, then resume
        b_hold = 1'b1;
        start_transfer(64'h10000, 640, -1);
        repeat (400) step();
        check("bp_aw_count", aw_seen, 4);
        check("bp_awvalid_low", M_AXI_AWVALID, 0);
        b_hold = 1'b0;
        wait_done(3000);
        check("bp_aw_total", aw_seen, 10);

        // SLVERR on the second of three responses, cleared by the next start
        start_transfer(64'h20000, 150, 1);
        wait_done(2000);
        start_transfer(64'h30000, 64, -1);
        wait_done(2000);

        // zero-length transfer
        start_transfer(64'h4000, 0, -1);
        wait_done(20);
        check("zero_no_aw", aw_seen, 0);

        // start while busy is ignored
        start_transfer(64'h5000, 128, -1);
        repeat (10) step();
        req_addr = 64'h0; req_cnt = 32'd7; start_req = 1'b1;
        step();
        step();
        check("busy_ignores_start", busy, 1);
        wait_done(2000);
        check("busy_start_beats", w_beats, 128);

        // asynchronous reset mid-transfer, then a clean run
        start_transfer(64'h6000, 150, -1);
        repeat (80) step();
        #2 reset = 1'b1;
        #1;
        check("midreset_outputs", {busy, done, error, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_WLAST, axis_tready}, 0);
        clear_model();
        repeat (3) step();
        reset = 1'b0;
        step();
        start_transfer(64'h7000, 100, -1);
        wait_done(2000);

        // random stalls on every channel
        p_tv = 70; p_wr = 60; p_awr = 50;
        for (int t = 0; t < 4; t++) begin
            logic [AW-1:0] a;
            a = AW'($urandom_range(0, 4095)) << 12;
            start_transfer(a, $urandom_range(1, 300), (t == 2) ? 0 : -1);
            wait_done(6000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
